// File: rtl/or_gate_pipe.sv
// or_gate_pipe: registered bitwise OR with a valid-tagged pipeline and any/all reduction flags.
// Optional OR_GATE_CNT_EN adds a saturating count of valid beats whose result is non-zero.
module or_gate_pipe #(
    parameter int WIDTH   = 1,
    parameter int LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] y,
    output logic             y_any,
    output logic             y_all
`ifdef OR_GATE_CNT_EN
    ,
    output logic [15:0]      ones_count
`endif
);

    if (WIDTH < 1 || WIDTH > 64 || LATENCY < 0 || LATENCY > 4) begin : g_bad_param
        $error("or_gate_pipe: illegal WIDTH=%0d or LATENCY=%0d", WIDTH, LATENCY);
    end

    if (LATENCY == 0) begin : g_comb
        assign out_valid = in_valid;
        assign y         = a | b;
    end else begin : g_pipe
        logic [LATENCY-1:0] vld_d, vld_q;
        logic [WIDTH-1:0]   dat_d [LATENCY];
        logic [WIDTH-1:0]   dat_q [LATENCY];
        // Data only advances behind a valid beat, so y holds its last result between beats.
        always_comb begin
            vld_d[0] = in_valid;
            dat_d[0] = in_valid ? (a | b) : dat_q[0];
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
                dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
            end
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < LATENCY; i++) dat_q[i] <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
            end
        end
        assign out_valid = vld_q[LATENCY-1];
        assign y         = dat_q[LATENCY-1];
    end

    assign y_any = |y;
    assign y_all = &y;

`ifdef OR_GATE_CNT_EN
    logic [15:0] cnt_d, cnt_q;
    always_comb cnt_d = (out_valid && y_any && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign ones_count = cnt_q;
`endif

endmodule

// File: tb/tb_or_gate_pipe.sv
// tb_or_gate_pipe: table-driven scoreboard bench for or_gate_pipe across several WIDTH/LATENCY builds.
// Counter checks compile in when OR_GATE_CNT_EN is defined.
module tb_or_gate_pipe;
    logic clk = 0;
    logic rst_n = 0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] iv = '0;
    logic [7:0] aa [3];
    logic [7:0] bb [3];
    logic [7:0] ey [3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : 8;
        localparam int L = g + 1;
        typedef struct { int due; logic [7:0] y; } exp_t;
        exp_t q [$];
        logic [W-1:0] y;
        logic ov, ya, yl;
        logic [7:0] last = '0;
        logic [7:0] e;
`ifdef OR_GATE_CNT_EN
        logic [15:0] cnt;
`endif
        or_gate_pipe #(.WIDTH(W), .LATENCY(L)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(iv[g]),
            .a(aa[g][W-1:0]),
            .b(bb[g][W-1:0]),
            .out_valid(ov),
            .y(y),
            .y_any(ya),
            .y_all(yl)
`ifdef OR_GATE_CNT_EN
            ,
            .ones_count(cnt)
`endif
        );
        always @(posedge clk) if (rst_n && iv[g]) q.push_back('{cyc + L, ey[g]});
        always @(negedge clk) begin
            if (!rst_n) begin
                chk($sformatf("L%0d reset out_valid", L), ov, 0);
                chk($sformatf("L%0d reset y", L), y, 0);
                chk($sformatf("L%0d reset y_any", L), ya, 0);
                chk($sformatf("L%0d reset y_all", L), yl, 0);
                q.delete();
                last = '0;
            end else if (q.size() > 0 && q[0].due == cyc) begin
                e = q[0].y;
                chk($sformatf("L%0d out_valid", L), ov, 1);
                chk($sformatf("L%0d y", L), y, e[W-1:0]);
                chk($sformatf("L%0d y_any", L), ya, |e[W-1:0]);
                chk($sformatf("L%0d y_all", L), yl, &e[W-1:0]);
                last = e;
                void'(q.pop_front());
            end else begin
                chk($sformatf("L%0d idle out_valid", L), ov, 0);
                chk($sformatf("L%0d hold y", L), y, last[W-1:0]);
            end
        end
    end

    logic       c_iv = 0;
    logic [3:0] c_a = '0, c_b = '0, c_y;
    logic       c_ov, c_any, c_all;
`ifdef OR_GATE_CNT_EN
    logic [15:0] c_cnt;
`endif
    or_gate_pipe #(.WIDTH(4), .LATENCY(0)) u_comb (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(c_iv),
        .a(c_a),
        .b(c_b),
        .out_valid(c_ov),
        .y(c_y),
        .y_any(c_any),
        .y_all(c_all)
`ifdef OR_GATE_CNT_EN
        ,
        .ones_count(c_cnt)
`endif
    );

    task automatic comb_chk(input logic v, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] ey_, input logic eany, input logic eall);
        c_iv = v; c_a = a; c_b = b;
        #1;
        chk("L0 out_valid", c_ov, v);
        chk("L0 y", c_y, ey_);
        chk("L0 y_any", c_any, eany);
        chk("L0 y_all", c_all, eall);
    endtask

    task automatic drive(input int k, input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] e);
        @(posedge clk); #1;
        iv = '0;
        iv[k] = v; aa[k] = a; bb[k] = b; ey[k] = e;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        iv = '0;
        repeat (n) @(posedge clk);
    endtask

    typedef struct { int inst; logic v; logic [7:0] a, b, y; } vec_t;
    vec_t vt [12];

    initial begin
        for (int k = 0; k < 3; k++) begin aa[k] = '0; bb[k] = '0; ey[k] = '0; end
        vt = '{'{0, 1, 8'h00, 8'h00, 8'h00},
               '{0, 1, 8'h00, 8'h01, 8'h01},
               '{0, 1, 8'h01, 8'h00, 8'h01},
               '{0, 1, 8'h01, 8'h01, 8'h01},
               '{1, 1, 8'h00, 8'h00, 8'h00},
               '{1, 0, 8'h11, 8'h22, 8'h33},
               '{1, 1, 8'hA5, 8'h5A, 8'hFF},
               '{2, 1, 8'h3C, 8'hC0, 8'hFC},
               '{2, 0, 8'hFF, 8'hFF, 8'hFF},
               '{2, 1, 8'h01, 8'h02, 8'h03},
               '{2, 1, 8'h80, 8'h00, 8'h80},
               '{0, 0, 8'h01, 8'h01, 8'h01}};
        #2;
        chk("reset L2 y", g_dut[1].y, 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1;

        for (int i = 0; i < 12; i++) drive(vt[i].inst, vt[i].v, vt[i].a, vt[i].b, vt[i].y);
        idle(6);

        comb_chk(1, 4'b0011, 4'b0100, 4'b0111, 1, 0);
        comb_chk(1, 4'b1111, 4'b0000, 4'b1111, 1, 1);
        comb_chk(0, 4'b0000, 4'b0000, 4'b0000, 0, 0);
        comb_chk(1, 4'b1000, 4'b0001, 4'b1001, 1, 0);

        // Two beats in flight on the LATENCY=2 pipe, then an asynchronous mid-cycle reset.
        drive(1, 1, 8'h0F, 8'h00, 8'h0F);
        drive(1, 1, 8'h30, 8'h00, 8'h30);
        @(posedge clk); #1;
        iv = '0;
        #2 rst_n = 0;
        #1;
        chk("async rst out_valid", g_dut[1].ov, 0);
        chk("async rst y", g_dut[1].y, 0);
        chk("async rst y_any", g_dut[1].ya, 0);
        chk("async rst y_all", g_dut[1].yl, 0);
        @(negedge clk);
        #2 rst_n = 1;
        repeat (6) @(posedge clk);

`ifdef OR_GATE_CNT_EN
        @(posedge clk); #3 rst_n = 0;
        @(negedge clk); #2 rst_n = 1;
        chk("cnt after reset", g_dut[0].cnt, 0);
        drive(0, 1, 8'h00, 8'h00, 8'h00);
        drive(0, 1, 8'h00, 8'h01, 8'h01);
        drive(0, 1, 8'h01, 8'h01, 8'h01);
        drive(0, 1, 8'h00, 8'h00, 8'h00);
        idle(3);
        chk("cnt stream", g_dut[0].cnt, 2);
        drive(0, 1, 8'h01, 8'h00, 8'h01);
        repeat (70000) @(posedge clk);
        idle(3);
        chk("cnt saturate", g_dut[0].cnt, 16'hFFFF);
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
